guess_timing_scheduler: RTL
===========================

Name: guess_timing_scheduler

Overview:
Sequences the guess/frame transmitter for the timing-attack experiment: sweeps candidate bytes, requests one frame per attempt, and times the gap between frame end and the NO/YES reply. Each candidate is attempted REPEATS times and the latencies are summed. The candidate with the largest summed latency is reported, or the candidate that drew YES. Sits between the top-level control (switch, LEDs) and the frame sender that drives the CM bus.

Parameters:
FIRST_GUESS, 8'h05, first candidate byte; also the reset value of cur_guess and best_byte
LAST_GUESS, 8'hFF, final candidate byte; must be >= FIRST_GUESS
REPEATS, 4, attempts per candidate (1..16)
CNT_W, 20, latency counter width
TIMEOUT, 20'hFFFFF, latency count at which an attempt is abandoned (< 2^CNT_W)

Ports:
clk  in  1  single clock
rst  in  1  asynchronous reset, active-high
start  in  1  pulse; begin a sweep (honoured in IDLE and DONE only)
abort  in  1  pulse; return to IDLE from any state
tx_req  out  1  request a START/DATA/END frame carrying tx_byte
tx_byte  out  8  candidate byte; stable while tx_req=1
tx_ack  in  1  one-cycle pulse from sender: END byte has been sent
rx_valid  in  1  one-cycle pulse: reply byte present on rx_data
rx_data  in  8  reply byte; 8'h03=YES, 8'h04=NO, all others ignored
busy  out  1  high in every state except IDLE and DONE
done  out  1  high in DONE
found  out  1  a YES reply was received
timeout_err  out  1  the sweep ended on a timeout
cur_guess  out  8  candidate currently under test (LED display)
best_byte  out  8  winner: the YES candidate, or the maximum-latency candidate
best_time  out  CNT_W+4  summed latency of best_byte

Behaviour:
- Reset (async): state=IDLE; tx_req=0; tx_byte=cur_guess=best_byte=FIRST_GUESS; best_time=0; found=timeout_err=done=busy=0.
- States: IDLE, LAUNCH, WAIT_TX, MEASURE, EVAL, DONE.
- IDLE/DONE, start=1: cur_guess=FIRST_GUESS, rep=0, acc=0, best_time=0, best_byte=FIRST_GUESS, found=timeout_err=0; go to LAUNCH.
- LAUNCH: single cycle; raises tx_req with tx_byte=cur_guess; go to WAIT_TX.
- WAIT_TX: tx_req held at 1 until tx_ack. On tx_ack: tx_req=0 in the next cycle, lat=1, go to MEASURE. rx_valid is ignored in WAIT_TX.
- MEASURE: lat increments every cycle.
  - With tx_ack at cycle T and rx_valid at cycle T+k, the recorded latency is k.
  - rx_valid with YES: found=1, best_byte=cur_guess, best_time=acc+k; go to DONE.
  - rx_valid with NO: acc+=k; if rep==REPEATS-1, go to EVAL; otherwise rep++ and go to LAUNCH.
  - rx_valid with any other byte: ignored, counting continues.
  - lat==TIMEOUT with no rx_valid: timeout_err=1; go to DONE. A valid reply in the same cycle as the timeout takes priority over the timeout.
- EVAL: single cycle.
  - If acc > best_time (strict), then best_time=acc and best_byte=cur_guess. On a tie the earlier byte is kept.
  - rep=0, acc=0.
  - If cur_guess==LAST_GUESS, go to DONE with found=0. Otherwise cur_guess++ and go to LAUNCH.
  - No wrap: LAST_GUESS=8'hFF terminates the sweep and does not wrap to 0.
- DONE: done=1. Result outputs are held until the next start.
- abort: highest priority. Next state is IDLE, tx_req=0, and results are not updated. abort together with start, tx_ack or rx_valid in the same cycle: abort wins.
- acc width is CNT_W+4, which cannot overflow for REPEATS<=16.

Test Plan:
- Reset, then start; sender acks 3 cycles after every tx_req; NO replies at k=10 for all bytes except 8'h42, which replies at k=25 -> done after a full sweep; best_byte=8'h42, best_time=100 (REPEATS=4), found=0.
- NO at k=10 for every byte except 8'h07, which replies YES at k=12 on its 2nd attempt -> found=1, best_byte=8'h07, best_time=22, done=1; no tx_req after the YES.
- All candidates reply at k=10 (tie) -> best_byte=8'h05, best_time=40.
- TIMEOUT=50, no reply -> at tx_ack+50, timeout_err=1 and done=1; a reply arriving at exactly k=50 -> accepted, no timeout.
- abort asserted during WAIT_TX, and again in the same cycle as tx_ack -> IDLE next cycle, tx_req=0, best_* unchanged; a following start restarts at 8'h05.
- Junk rx_data=8'h01 mid-MEASURE, followed by NO at k=30 -> recorded latency is 30; rx_valid during WAIT_TX is ignored. Also assert rst asynchronously mid-MEASURE -> all outputs at their reset values immediately.

Source files
------------

// File: rtl/guess_timing_scheduler.sv
// Guess/frame sequencer for the timing-attack sweep. It walks the candidate
// bytes, requests one frame per attempt and times the gap from the frame-end
// ack to the NO/YES reply. Latencies are summed over REPEATS attempts, and it
// reports either the byte that drew YES or the byte with the largest sum.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | waiting for start, no sweep has run since reset/abort
// LAUNCH  | one cycle: raise tx_req with the current candidate
// WAIT_TX | tx_req held until the sender acks the END byte
// MEASURE | latency counter running until a NO/YES reply or the timeout
// EVAL    | one cycle: compare summed latency, advance to the next candidate
// DONE    | sweep finished; results held until the next start
module guess_timing_scheduler #(
  parameter logic [7:0]       FIRST_GUESS = 8'h05,
  parameter logic [7:0]       LAST_GUESS  = 8'hFF,
  parameter int unsigned      REPEATS     = 4,
  parameter int unsigned      CNT_W       = 20,
  parameter logic [CNT_W-1:0] TIMEOUT     = 20'hFFFFF
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               start_i,
  input  logic               abort_i,
  output logic               tx_req_o,
  output logic [7:0]         tx_byte_o,
  input  logic               tx_ack_i,
  input  logic               rx_valid_i,
  input  logic [7:0]         rx_data_i,
  output logic               busy_o,
  output logic               done_o,
  output logic               found_o,
  output logic               timeout_err_o,
  output logic [7:0]         cur_guess_o,
  output logic [7:0]         best_byte_o,
  output logic [CNT_W+3:0]   best_time_o
);

  localparam int unsigned ACC_W   = CNT_W + 4;
  localparam logic [7:0]  RX_YES  = 8'h03;
  localparam logic [7:0]  RX_NO   = 8'h04;
  localparam logic [3:0]  REP_MAX = 4'(REPEATS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LAUNCH, S_WAIT_TX, S_MEASURE, S_EVAL, S_DONE
  } state_t;

  state_t             state_q;
  logic               tx_req_q;
  logic [7:0]         tx_byte_q;
  logic               busy_q;
  logic               done_q;
  logic               found_q;
  logic               timeout_err_q;
  logic [7:0]         cur_guess_q;
  logic [7:0]         best_byte_q;
  logic [ACC_W-1:0]   best_time_q;
  logic [ACC_W-1:0]   acc_q;
  logic [CNT_W-1:0]   lat_q;
  logic [3:0]         rep_q;

  // Sum including the reply that arrives this cycle; lat_q already equals k.
  logic [ACC_W-1:0]   acc_plus_lat;
  assign acc_plus_lat = acc_q + ACC_W'(lat_q);

  // Sweep sequencer: state, latency timing and result registers in one place.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q       <= S_IDLE;
      tx_req_q      <= 1'b0;
      tx_byte_q     <= FIRST_GUESS;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      found_q       <= 1'b0;
      timeout_err_q <= 1'b0;
      cur_guess_q   <= FIRST_GUESS;
      best_byte_q   <= FIRST_GUESS;
      best_time_q   <= '0;
      acc_q         <= '0;
      lat_q         <= '0;
      rep_q         <= '0;
    end else if (abort_i) begin
      // Abort drops the request and leaves every result register untouched.
      state_q  <= S_IDLE;
      tx_req_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start_i) begin
            cur_guess_q   <= FIRST_GUESS;
            rep_q         <= '0;
            acc_q         <= '0;
            best_time_q   <= '0;
            best_byte_q   <= FIRST_GUESS;
            found_q       <= 1'b0;
            timeout_err_q <= 1'b0;
            busy_q        <= 1'b1;
            done_q        <= 1'b0;
            state_q       <= S_LAUNCH;
          end
        end
        S_LAUNCH: begin
          tx_req_q  <= 1'b1;
          tx_byte_q <= cur_guess_q;
          state_q   <= S_WAIT_TX;
        end
        S_WAIT_TX: begin
          // Replies before the frame has gone out are stale and ignored.
          if (tx_ack_i) begin
            tx_req_q <= 1'b0;
            lat_q    <= {{(CNT_W-1){1'b0}}, 1'b1};
            state_q  <= S_MEASURE;
          end
        end
        S_MEASURE: begin
          // A valid reply on the timeout cycle still counts as a reply.
          if (rx_valid_i && rx_data_i == RX_YES) begin
            found_q     <= 1'b1;
            best_byte_q <= cur_guess_q;
            best_time_q <= acc_plus_lat;
            busy_q      <= 1'b0;
            done_q      <= 1'b1;
            state_q     <= S_DONE;
          end else if (rx_valid_i && rx_data_i == RX_NO) begin
            acc_q <= acc_plus_lat;
            if (rep_q == REP_MAX) begin
              state_q <= S_EVAL;
            end else begin
              rep_q   <= rep_q + 4'd1;
              state_q <= S_LAUNCH;
            end
          end else if (lat_q == TIMEOUT) begin
            timeout_err_q <= 1'b1;
            busy_q        <= 1'b0;
            done_q        <= 1'b1;
            state_q       <= S_DONE;
          end else begin
            lat_q <= lat_q + {{(CNT_W-1){1'b0}}, 1'b1};
          end
        end
        S_EVAL: begin
          // Strict compare: on a tie the earlier candidate keeps the title.
          if (acc_q > best_time_q) begin
            best_time_q <= acc_q;
            best_byte_q <= cur_guess_q;
          end
          rep_q <= '0;
          acc_q <= '0;
          if (cur_guess_q == LAST_GUESS) begin
            found_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end else begin
            cur_guess_q <= cur_guess_q + 8'd1;
            state_q     <= S_LAUNCH;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign tx_req_o      = tx_req_q;
  assign tx_byte_o     = tx_byte_q;
  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign found_o       = found_q;
  assign timeout_err_o = timeout_err_q;
  assign cur_guess_o   = cur_guess_q;
  assign best_byte_o   = best_byte_q;
  assign best_time_o   = best_time_q;

endmodule
